// File: rtl/frame_composer.sv
// Walks every framebuffer pixel once in raster order and writes it through a gated write port,
// composing scrolled background, keyed/mirrored sprite, or a saturating fade of the current frame.
module frame_composer #(
  parameter int          FB_W      = 240,
  parameter int          FB_H      = 160,
  parameter int          MAP_W     = 471,
  parameter int          SPR_W     = 16,
  parameter int          SPR_H     = 21,
  parameter int          SHEET_W   = 271,
  parameter logic [23:0] KEY       = 24'hFF00FF,
  parameter logic [7:0]  FADE_STEP = 8'd5,
  parameter int          AW        = 19
) (
  input  logic          Clk,
  input  logic          Reset_n,
  input  logic          start,
  input  logic [1:0]    mode,
  input  logic          wr_allow,
  input  logic [9:0]    map_x,
  input  logic [9:0]    map_y,
  input  logic [9:0]    spr_x,
  input  logic [9:0]    spr_y,
  input  logic [3:0]    spr_row,
  input  logic [3:0]    spr_col,
  input  logic          spr_mirror,
  output logic [AW-1:0] map_addr,
  input  logic [23:0]   map_data,
  output logic [AW-1:0] spr_addr,
  input  logic [23:0]   spr_data,
  output logic [AW-1:0] fbr_addr,
  input  logic [23:0]   fbr_data,
  output logic          fb_we,
  output logic [AW-1:0] fb_waddr,
  output logic [23:0]   fb_wdata,
  output logic          busy,
  output logic          done,
  output logic [1:0]    state_dbg
);

  // Handshake: a pixel leaves the pipe only on a cycle where fb_we and wr_allow are both high;
  // wr_allow=0 freezes every stage so the same pixel is offered again on the next allowed cycle.

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [1:0] M_COMPOSE = 2'd1;
  localparam logic [1:0] M_FADE    = 2'd2;

  state_t state_q, state_d;

  logic [1:0]  mode_q;
  logic [9:0]  map_x_q, map_y_q, spr_x_q, spr_y_q;
  logic [3:0]  spr_row_q, spr_col_q;
  logic        spr_mirror_q;

  logic [9:0]  x_q, y_q;
  logic        s0_valid, s1_valid, s2_valid;
  logic [AW-1:0] s1_addr;
  logic        s1_inbox;
  logic        adv_q;
  logic [23:0] map_hold, spr_hold, fbr_hold;

  logic        accept, advance, last_px;
  logic [9:0]  dx, dy, cx;
  logic        in_box;
  logic [AW-1:0] map_lin, spr_lin, fb_lin;
  logic [23:0] map_d, spr_d, fbr_d, pix;

  assign accept    = (state_q == S_IDLE) && start;
  assign advance   = (state_q == S_RUN) && wr_allow;
  assign last_px   = (x_q == 10'(FB_W - 1)) && (y_q == 10'(FB_H - 1));
  assign state_dbg = state_q;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      S_IDLE: if (start) state_d = S_RUN;
      S_RUN: begin
        busy = 1'b1;
        if (advance && s2_valid && !s1_valid && !s0_valid) state_d = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      mode_q       <= '0;
      map_x_q      <= '0;
      map_y_q      <= '0;
      spr_x_q      <= '0;
      spr_y_q      <= '0;
      spr_row_q    <= '0;
      spr_col_q    <= '0;
      spr_mirror_q <= 1'b0;
    end else if (accept) begin
      mode_q       <= mode;
      map_x_q      <= map_x;
      map_y_q      <= map_y;
      spr_x_q      <= spr_x;
      spr_y_q      <= spr_y;
      spr_row_q    <= spr_row;
      spr_col_q    <= spr_col;
      spr_mirror_q <= spr_mirror;
    end
  end

  // S0: raster counter and read addresses for the pixel it holds
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      x_q      <= '0;
      y_q      <= '0;
      s0_valid <= 1'b0;
    end else if (accept) begin
      x_q      <= '0;
      y_q      <= '0;
      s0_valid <= 1'b1;
    end else if (advance && s0_valid) begin
      if (last_px) begin
        s0_valid <= 1'b0;
      end else if (x_q == 10'(FB_W - 1)) begin
        x_q <= '0;
        y_q <= y_q + 10'd1;
      end else begin
        x_q <= x_q + 10'd1;
      end
    end
  end

  always_comb begin
    dx      = x_q - spr_x_q;
    dy      = y_q - spr_y_q;
    in_box  = (dx < 10'(SPR_W)) && (dy < 10'(SPR_H));
    cx      = spr_mirror_q ? (10'(SPR_W - 1) - dx) : dx;
    map_lin = (AW'(y_q) + AW'(map_y_q)) * AW'(MAP_W) + AW'(x_q) + AW'(map_x_q);
    spr_lin = (AW'(spr_row_q) * AW'(SPR_H) + AW'(dy)) * AW'(SHEET_W)
              + AW'(spr_col_q) * AW'(SPR_W) + AW'(cx);
    fb_lin  = AW'(y_q) * AW'(FB_W) + AW'(x_q);
  end

  assign map_addr = s0_valid ? map_lin : '0;
  assign spr_addr = (s0_valid && in_box) ? spr_lin : '0;
  assign fbr_addr = s0_valid ? fb_lin : '0;

  // S1: read data is live only on the cycle right after an advance; during a stall the
  // addresses have already moved on, so the copy captured on that first cycle is used instead.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      s1_valid <= 1'b0;
      s1_addr  <= '0;
      s1_inbox <= 1'b0;
      adv_q    <= 1'b0;
      map_hold <= '0;
      spr_hold <= '0;
      fbr_hold <= '0;
    end else begin
      adv_q <= advance;
      if (adv_q) begin
        map_hold <= map_data;
        spr_hold <= spr_data;
        fbr_hold <= fbr_data;
      end
      if (advance) begin
        s1_valid <= s0_valid;
        s1_addr  <= fb_lin;
        s1_inbox <= in_box;
      end
    end
  end

  assign map_d = adv_q ? map_data : map_hold;
  assign spr_d = adv_q ? spr_data : spr_hold;
  assign fbr_d = adv_q ? fbr_data : fbr_hold;

  function automatic logic [7:0] fade_ch(input logic [7:0] c);
    return (c < FADE_STEP) ? 8'd0 : c - FADE_STEP;
  endfunction

  always_comb begin
    case (mode_q)
      M_COMPOSE: pix = (s1_inbox && spr_d != KEY) ? spr_d : map_d;
      M_FADE:    pix = {fade_ch(fbr_d[23:16]), fade_ch(fbr_d[15:8]), fade_ch(fbr_d[7:0])};
      default:   pix = map_d;
    endcase
  end

  // S2: registered write request, released to the framebuffer only while wr_allow is high
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      s2_valid <= 1'b0;
      fb_waddr <= '0;
      fb_wdata <= '0;
    end else if (advance) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        fb_waddr <= s1_addr;
        fb_wdata <= pix;
      end
    end
  end

  assign fb_we = s2_valid && wr_allow;

endmodule

// File: tb/tb_frame_composer.sv
// Self-checking bench for frame_composer: ROM/framebuffer models, per-pixel scoreboard,
// spot checks on sprite, mirror, wrap and fade pixels, stall and reset-abort scenarios.
module tb_frame_composer;

  localparam int          FB_W    = 110;
  localparam int          FB_H    = 56;
  localparam int          NPIX    = FB_W * FB_H;
  localparam int          MAP_W   = 471;
  localparam int          SPR_W   = 16;
  localparam int          SPR_H   = 21;
  localparam int          SHEET_W = 271;
  localparam logic [23:0] KEY     = 24'hFF00FF;
  localparam int          AW      = 19;
  localparam int          W       = AW + 24;
  localparam int          KEY_ADDR = (1 * SPR_H + 1) * SHEET_W + 2 * SPR_W + 2;

  logic          Clk = 1'b0;
  logic          Reset_n;
  logic          start;
  logic [1:0]    mode;
  logic          wr_allow;
  logic [9:0]    map_x, map_y, spr_x, spr_y;
  logic [3:0]    spr_row, spr_col;
  logic          spr_mirror;
  logic [AW-1:0] map_addr, spr_addr, fbr_addr, fb_waddr;
  logic [23:0]   map_data, spr_data, fbr_data, fb_wdata;
  logic          fb_we, busy, done;
  logic [1:0]    state_dbg;

  frame_composer #(
    .FB_W(FB_W), .FB_H(FB_H), .MAP_W(MAP_W), .SPR_W(SPR_W), .SPR_H(SPR_H),
    .SHEET_W(SHEET_W), .KEY(KEY), .FADE_STEP(8'd5), .AW(AW)
  ) dut (
    .Clk(Clk), .Reset_n(Reset_n), .start(start), .mode(mode), .wr_allow(wr_allow),
    .map_x(map_x), .map_y(map_y), .spr_x(spr_x), .spr_y(spr_y),
    .spr_row(spr_row), .spr_col(spr_col), .spr_mirror(spr_mirror),
    .map_addr(map_addr), .map_data(map_data), .spr_addr(spr_addr), .spr_data(spr_data),
    .fbr_addr(fbr_addr), .fbr_data(fbr_data), .fb_we(fb_we), .fb_waddr(fb_waddr),
    .fb_wdata(fb_wdata), .busy(busy), .done(done), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int start_cyc = 0;
  int writes   = 0;
  int done_cnt = 0;
  bit first_pending = 1'b0;
  bit stall_en = 1'b0;

  logic [W-1:0] exp_q[$];
  logic [23:0]  fb [0:NPIX-1];

  int cfg_mode, cfg_mx, cfg_my, cfg_sx, cfg_sy, cfg_row, cfg_col, cfg_mir;

  always @(posedge Clk) cyc++;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  function automatic logic [23:0] map_fn(input int a);
    logic [31:0] h;
    h = 32'(a) * 32'h9E3779B1;
    return h[31:8];
  endfunction

  function automatic logic [23:0] spr_fn(input int a);
    logic [31:0] h;
    if (a % 13 == 7 || a == KEY_ADDR) return KEY;
    h = (32'(a) * 32'h85EBCA6B) ^ 32'h01234567;
    return h[27:4];
  endfunction

  function automatic logic [7:0] fade8(input logic [7:0] c);
    return (int'(c) < 5) ? 8'd0 : 8'(int'(c) - 5);
  endfunction

  function automatic logic [23:0] model_pix(input int x, input int y);
    int ma, dx, dy, cx, sa;
    logic [23:0] f, s;
    if (cfg_mode == 2) begin
      f = fb[y * FB_W + x];
      return {fade8(f[23:16]), fade8(f[15:8]), fade8(f[7:0])};
    end
    if (cfg_mode == 1) begin
      dx = (x - cfg_sx) & 1023;
      dy = (y - cfg_sy) & 1023;
      if (dx < SPR_W && dy < SPR_H) begin
        cx = (cfg_mir != 0) ? (SPR_W - 1 - dx) : dx;
        sa = (cfg_row * SPR_H + dy) * SHEET_W + cfg_col * SPR_W + cx;
        s  = spr_fn(sa);
        if (s != KEY) return s;
      end
    end
    ma = ((y + cfg_my) * MAP_W + x + cfg_mx) & ((1 << AW) - 1);
    return map_fn(ma);
  endfunction

  // memory models: registered reads, one cycle latency
  always @(posedge Clk) begin
    map_data <= map_fn(int'(map_addr));
    spr_data <= spr_fn(int'(spr_addr));
    fbr_data <= (int'(fbr_addr) < NPIX) ? fb[fbr_addr] : 24'h0;
  end

  // scoreboard / monitor
  always @(negedge Clk) begin
    if (fb_we) begin
      logic [W-1:0] e;
      writes++;
      if (exp_q.size() == 0) begin
        check("unexpected_write", 64'(exp_q.size()), 64'd1);
      end else begin
        e = exp_q.pop_front();
        check("pixel", 64'({fb_waddr, fb_wdata}), 64'(e));
      end
      if (first_pending) begin
        check("first_write_latency", 64'(cyc - start_cyc), 64'd3);
        first_pending = 1'b0;
      end
      if (int'(fb_waddr) < NPIX) fb[fb_waddr] = fb_wdata;
    end
    if (done) done_cnt++;
  end

  initial begin
    wr_allow = 1'b1;
    forever begin
      @(posedge Clk);
      #1;
      wr_allow = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // driver tasks
  task automatic set_cfg(input int m, input int mx, input int my, input int sx, input int sy,
                         input int row, input int col, input int mir);
    cfg_mode = (m == 3) ? 0 : m;
    cfg_mx = mx; cfg_my = my; cfg_sx = sx; cfg_sy = sy;
    cfg_row = row; cfg_col = col; cfg_mir = mir;
    mode = 2'(m); map_x = 10'(mx); map_y = 10'(my); spr_x = 10'(sx); spr_y = 10'(sy);
    spr_row = 4'(row); spr_col = 4'(col); spr_mirror = 1'(mir);
  endtask

  task automatic push_frame();
    for (int y = 0; y < FB_H; y++)
      for (int x = 0; x < FB_W; x++)
        exp_q.push_back({AW'(y * FB_W + x), model_pix(x, y)});
  endtask

  task automatic pulse_start(input bit check_lat);
    @(posedge Clk);
    #1;
    start = 1'b1;
    start_cyc = cyc;
    first_pending = check_lat;
    @(posedge Clk);
    #1;
    start = 1'b0;
  endtask

  task automatic run_frame(input bit stall, input bit poke_start);
    int  base_done, base_wr;
    bit  got;
    base_done = done_cnt;
    base_wr   = writes;
    push_frame();
    stall_en = stall;
    pulse_start(!stall);
    if (poke_start) begin
      repeat (50) @(posedge Clk);
      #1;
      check("busy_mid_frame", 64'(busy), 64'd1);
      start = 1'b1; mode = 2'd2; map_x = map_x + 10'd7; spr_mirror = ~spr_mirror;
      @(posedge Clk);
      #1;
      start = 1'b0;
    end
    got = 1'b0;
    for (int i = 0; i < 4 * NPIX + 100 && !got; i++) begin
      @(negedge Clk);
      if (done_cnt != base_done) got = 1'b1;
    end
    check("done_seen", 64'(got), 64'd1);
    stall_en = 1'b0;
    repeat (5) @(negedge Clk);
    check("done_pulses", 64'(done_cnt - base_done), 64'd1);
    check("write_count", 64'(writes - base_wr), 64'(NPIX));
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    check("busy_after", 64'(busy), 64'd0);
    check("state_idle", 64'(state_dbg), 64'd0);
  endtask

  initial begin
    for (int i = 0; i < NPIX; i++) fb[i] = map_fn(i * 7 + 11) ^ 24'h00FF00;
    Reset_n = 1'b0;
    start = 1'b0;
    set_cfg(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(posedge Clk);
    #1;
    check("rst_fb_we", 64'(fb_we), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_state", 64'(state_dbg), 64'd0);
    check("rst_waddr", 64'(fb_waddr), 64'd0);
    check("rst_wdata", 64'(fb_wdata), 64'd0);
    check("rst_map_addr", 64'(map_addr), 64'd0);
    Reset_n = 1'b1;
    repeat (2) @(posedge Clk);

    // reserved mode behaves as COPY; a start while busy (with new inputs) must be ignored
    set_cfg(3, 3, 2, 0, 0, 0, 0, 0);
    run_frame(1'b0, 1'b1);
    check("copy_first_px", 64'(fb[0]), 64'(map_fn(2 * MAP_W + 3)));

    set_cfg(1, 5, 4, 100, 50, 1, 2, 0);
    run_frame(1'b0, 1'b0);
    check("compose_key_px", 64'(fb[51 * FB_W + 102]), 64'(map_fn((51 + 4) * MAP_W + 102 + 5)));
    check("compose_spr_px", 64'(fb[50 * FB_W + 100]), 64'(spr_fn(21 * SHEET_W + 32)));

    set_cfg(1, 5, 4, 100, 50, 1, 2, 1);
    run_frame(1'b1, 1'b0);
    check("mirror_spr_px", 64'(fb[50 * FB_W + 100]), 64'(spr_fn(21 * SHEET_W + 32 + 15)));

    set_cfg(1, 0, 0, 1020, 50, 1, 2, 0);
    run_frame(1'b0, 1'b0);
    check("wrap_no_spr_px", 64'(fb[50 * FB_W + 100]), 64'(map_fn(50 * MAP_W + 100)));
    check("wrap_edge_px", 64'(fb[50 * FB_W + 1]), 64'(spr_fn(21 * SHEET_W + 32 + 5)));

    fb[0] = 24'h04FF05;
    fb[1] = 24'h050506;
    set_cfg(2, 0, 0, 0, 0, 0, 0, 0);
    run_frame(1'b1, 1'b0);
    check("fade_px0", 64'(fb[0]), 64'h00FA00);
    check("fade_px1", 64'(fb[1]), 64'h000001);

    // abort mid-frame with an asynchronous reset, then redraw from scratch
    set_cfg(0, 3, 2, 0, 0, 0, 0, 0);
    push_frame();
    begin
      int base_done;
      base_done = done_cnt;
      pulse_start(1'b1);
      repeat (300) @(posedge Clk);
      #2;
      Reset_n = 1'b0;
      #1;
      check("abort_fb_we", 64'(fb_we), 64'd0);
      check("abort_busy", 64'(busy), 64'd0);
      check("abort_done", 64'(done), 64'd0);
      exp_q.delete();
      @(posedge Clk);
      #1;
      Reset_n = 1'b1;
      repeat (20) @(negedge Clk);
      check("abort_no_done", 64'(done_cnt - base_done), 64'd0);
      check("abort_stays_idle", 64'(busy), 64'd0);
    end
    for (int i = 0; i < NPIX; i++) fb[i] = 24'h0;
    run_frame(1'b0, 1'b0);
    check("redraw_first_px", 64'(fb[0]), 64'(map_fn(2 * MAP_W + 3)));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
